dispatch_lane_scheduler: RTL and testbench

- Sequences thread dispatch for one 256-bit active-mask chunk across 4 CGRA unrolling lanes.
- Gathers each lane's 64-bit slice according to the unrolling factor, then emits one active thread per lane per handshake until the chunk is drained.
- Per lane, a 64-bit lowest-set-bit priority encoder feeds the existing reverse_mapper, giving the 8-bit active-mask index.
- Sits between the warp/chunk issue stage and the CGRA lane dispatch ports.

---
 rtl/dispatch_sched_pkg.sv | 36 +++
 rtl/pe64_lowest.sv | 20 ++
 rtl/reverse_mapper.sv | 22 ++
 rtl/dispatch_lane_scheduler.sv | 157 +++++++++++++++
 tb/tb_dispatch_lane_scheduler.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/dispatch_sched_pkg.sv
// Shared types and helpers for the dispatch lane scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dispatch_sched_pkg;

    localparam int NUM_LANES = 4;
    localparam int SLICE_W   = 64;

    typedef enum logic [1:0] {
        UNROLL_1 = 2'd0,
        UNROLL_2 = 2'd1,
        UNROLL_4 = 2'd2
    } unroll_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } sched_state_e;

    // Mask bit that feeds slice position 'pos' of 'lane' under 'factor'.
    // This is the inverse view of reverse_mapper; factor 3 is illegal and maps to 0.
    function automatic logic [7:0] gather_index(input logic [1:0] lane,
                                                input logic [5:0] pos,
                                                input logic [1:0] factor);
        logic [7:0] idx;
        case (factor)
            UNROLL_1: idx = {lane, pos};
            UNROLL_2: idx = {lane[1], pos[5:4], lane[0], pos[3:0]};
            UNROLL_4: idx = {pos[5:3], lane, pos[2:0]};
            default:  idx = 8'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/pe64_lowest.sv
// 64-bit lowest-set-bit priority encoder (bit 0 highest priority, bit 63 lowest).
// Latency: combinational.
// Backpressure: none.
// Ports: vec_i (input vector), pos_o (index of lowest set bit, 0 if none), valid_o (any bit set).
module pe64_lowest (
    input  logic [63:0] vec_i,
    output logic [5:0]  pos_o,
    output logic        valid_o
);
    always_comb begin
        pos_o   = 6'd0;
        valid_o = |vec_i;
        // Scan downward so the last hit written is the lowest set bit.
        for (int i = 63; i >= 0; i--) begin
            if (vec_i[i]) begin
                pos_o = 6'(i);
            end
        end
    end
endmodule

// File: rtl/reverse_mapper.sv
// Maps a lane slice position back to its 8-bit active-mask index.
// Latency: combinational.
// Backpressure: none.
// Ports: pos_i (slice position), factor_i (unroll factor, 3 -> index 0), idx_o (mask index).
module reverse_mapper #(
    parameter int UNROLLING_INDEX = 0
) (
    input  logic [5:0] pos_i,
    input  logic [1:0] factor_i,
    output logic [7:0] idx_o
);
    localparam logic [1:0] LANE = 2'(UNROLLING_INDEX);

    always_comb begin
        case (factor_i)
            2'd0:    idx_o = {LANE, pos_i};
            2'd1:    idx_o = {LANE[1], pos_i[5:4], LANE[0], pos_i[3:0]};
            2'd2:    idx_o = {pos_i[5:3], LANE, pos_i[2:0]};
            default: idx_o = 8'd0;
        endcase
    end
endmodule

// File: rtl/dispatch_lane_scheduler.sv
// Drains one 256-bit active-mask chunk across 4 lanes, one thread per lane per handshake.
// Latency: first bundle 1 cycle after accept; done_o 1 cycle after the last bundle's cycle + 1 (2 after accept if empty/illegal).
// Backpressure: disp_valid_o/disp_ready_i handshake; outputs held while stalled; mask_ready_o only in IDLE.
// Ports: mask_* chunk request (valid/ready), unroll_factor_i, chunk_id_i; disp_* per-lane dispatch bundle
// (tid = {chunk_id, mask index}, lane 0 in LSBs); done_o/err_o one-cycle pulses; busy_o = not idle.
// Optional: DISPATCH_SCHED_PERF_EN adds perf_o = {stall_cycles, dispatch_cycles, chunks}, saturating.
module dispatch_lane_scheduler
    import dispatch_sched_pkg::*;
#(
    parameter int CHUNK_ID_W = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                mask_valid_i,
    output logic                                mask_ready_o,
    input  logic [255:0]                        mask_i,
    input  logic [1:0]                          unroll_factor_i,
    input  logic [CHUNK_ID_W-1:0]               chunk_id_i,
    output logic                                disp_valid_o,
    input  logic                                disp_ready_i,
    output logic [NUM_LANES-1:0]                disp_lane_valid_o,
    output logic [NUM_LANES*(CHUNK_ID_W+8)-1:0] disp_tid_o,
    output logic                                done_o,
    output logic                                err_o,
`ifdef DISPATCH_SCHED_PERF_EN
    output logic [95:0]                         perf_o,
`endif
    output logic                                busy_o
);
    localparam int TID_W = CHUNK_ID_W + 8;

    sched_state_e                       state_q, state_d;
    logic [NUM_LANES-1:0][SLICE_W-1:0]  pend_q, pend_d;
    logic [1:0]                         factor_q, factor_d;
    logic [CHUNK_ID_W-1:0]              chunk_id_q, chunk_id_d;
    logic                               err_pend_q, err_pend_d;
    logic                               done_q, done_d;
    logic                               err_q, err_d;

    logic [5:0]                         enc [NUM_LANES];
    logic [7:0]                         rm_idx [NUM_LANES];
    logic [NUM_LANES-1:0]               lane_vld;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        pe64_lowest u_pe (
            .vec_i   (pend_q[l]),
            .pos_o   (enc[l]),
            .valid_o (lane_vld[l])
        );
        reverse_mapper #(.UNROLLING_INDEX(l)) u_rm (
            .pos_i    (enc[l]),
            .factor_i (factor_q),
            .idx_o    (rm_idx[l])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            factor_q   <= 2'd0;
            chunk_id_q <= '0;
            err_pend_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            factor_q   <= factor_d;
            chunk_id_q <= chunk_id_d;
            err_pend_q <= err_pend_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        pend_d            = pend_q;
        factor_d          = factor_q;
        chunk_id_d        = chunk_id_q;
        err_pend_d        = err_pend_q;
        done_d            = 1'b0;
        err_d             = 1'b0;
        mask_ready_o      = 1'b0;
        disp_valid_o      = 1'b0;
        disp_lane_valid_o = '0;
        disp_tid_o        = '0;

        case (state_q)
            ST_IDLE: begin
                mask_ready_o = 1'b1;
                if (mask_valid_i) begin
                    factor_d   = unroll_factor_i;
                    chunk_id_d = chunk_id_i;
                    err_pend_d = (unroll_factor_i == 2'd3);
                    for (int l = 0; l < NUM_LANES; l++) begin
                        for (int p = 0; p < SLICE_W; p++) begin
                            pend_d[l][p] = (unroll_factor_i != 2'd3) &&
                                           mask_i[gather_index(2'(l), 6'(p), unroll_factor_i)];
                        end
                    end
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                disp_lane_valid_o = lane_vld;
                disp_valid_o      = |lane_vld;
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (lane_vld[l]) begin
                        disp_tid_o[l*TID_W +: TID_W] = {chunk_id_q, rm_idx[l]};
                    end
                end
                if (!disp_valid_o) begin
                    // Chunk drained: done/err pulse is registered into the FLUSH cycle.
                    state_d = ST_FLUSH;
                    done_d  = 1'b1;
                    err_d   = err_pend_q;
                end else if (disp_ready_i) begin
                    // x & (x-1) clears exactly the lowest set bit, i.e. bit enc[l];
                    // for an empty lane it stays zero.
                    for (int l = 0; l < NUM_LANES; l++) begin
                        pend_d[l] = pend_q[l] & (pend_q[l] - 64'd1);
                    end
                end
            end
            ST_FLUSH: begin
                err_pend_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done_o = done_q;
    assign err_o  = err_q;
    assign busy_o = (state_q != ST_IDLE);

`ifdef DISPATCH_SCHED_PERF_EN
    logic [31:0] stall_cnt_q, disp_cnt_q, chunk_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            disp_cnt_q  <= '0;
            chunk_cnt_q <= '0;
        end else begin
            if (disp_valid_o && !disp_ready_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (disp_valid_o && disp_ready_i && disp_cnt_q != '1)   disp_cnt_q  <= disp_cnt_q + 32'd1;
            if (done_q && chunk_cnt_q != '1)                        chunk_cnt_q <= chunk_cnt_q + 32'd1;
        end
    end

    assign perf_o = {stall_cnt_q, disp_cnt_q, chunk_cnt_q};
`endif

endmodule

// File: tb/tb_dispatch_lane_scheduler.sv
// Directed bench for dispatch_lane_scheduler with hand-computed tids and pulse timing.
// Latency: n/a.
// Backpressure: drives disp_ready_i low for selected cycles.
module tb_dispatch_lane_scheduler;
    logic         clk = 1'b0;
    logic         reset;
    logic         mask_valid_i;
    logic         mask_ready_o;
    logic [255:0] mask_i;
    logic [1:0]   unroll_factor_i;
    logic [3:0]   chunk_id_i;
    logic         disp_valid_o;
    logic         disp_ready_i;
    logic [3:0]   disp_lane_valid_o;
    logic [47:0]  disp_tid_o;
    logic         done_o;
    logic         err_o;
    logic         busy_o;
`ifdef DISPATCH_SCHED_PERF_EN
    logic [95:0]  perf_o;
`endif

    int checks = 0;
    int errors = 0;

    dispatch_lane_scheduler #(.CHUNK_ID_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .mask_valid_i      (mask_valid_i),
        .mask_ready_o      (mask_ready_o),
        .mask_i            (mask_i),
        .unroll_factor_i   (unroll_factor_i),
        .chunk_id_i        (chunk_id_i),
        .disp_valid_o      (disp_valid_o),
        .disp_ready_i      (disp_ready_i),
        .disp_lane_valid_o (disp_lane_valid_o),
        .disp_tid_o        (disp_tid_o),
        .done_o            (done_o),
        .err_o             (err_o),
`ifdef DISPATCH_SCHED_PERF_EN
        .perf_o            (perf_o),
`endif
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] tid(input int lane);
        return disp_tid_o[lane*12 +: 12];
    endfunction

    // Present a chunk for one edge; returns in the first RUN cycle.
    task automatic accept(input logic [255:0] m, input logic [1:0] f, input logic [3:0] id);
        check("accept_ready", 64'(mask_ready_o), 64'd1);
        mask_i          = m;
        unroll_factor_i = f;
        chunk_id_i      = id;
        mask_valid_i    = 1'b1;
        step();
        mask_valid_i    = 1'b0;
        mask_i          = '0;
    endtask

    // Empty RUN cycle, then FLUSH with done, then back to IDLE.
    task automatic expect_tail(input string tag, input logic exp_err);
        check({tag, "_drain_vld"}, 64'(disp_valid_o), 64'd0);
        check({tag, "_drain_done"}, 64'(done_o), 64'd0);
        step();
        check({tag, "_done"}, 64'(done_o), 64'd1);
        check({tag, "_err"}, 64'(err_o), 64'(exp_err));
        check({tag, "_flush_rdy"}, 64'(mask_ready_o), 64'd0);
        step();
        check({tag, "_done_clr"}, {62'd0, done_o, err_o}, 64'd0);
        check({tag, "_idle_rdy"}, {62'd0, mask_ready_o, busy_o}, 64'b10);
    endtask

    initial begin
        logic [255:0] m;
        reset           = 1'b1;
        mask_valid_i    = 1'b0;
        mask_i          = '0;
        unroll_factor_i = 2'd0;
        chunk_id_i      = 4'd0;
        disp_ready_i    = 1'b1;
        step();
        step();
        check("rst_ready", 64'(mask_ready_o), 64'd1);
        check("rst_outs", {58'd0, disp_valid_o, disp_lane_valid_o, done_o}, 64'd0);
        check("rst_tid", 64'(disp_tid_o), 64'd0);
        check("rst_err_busy", {62'd0, err_o, busy_o}, 64'd0);
        reset = 1'b0;
        step();

        // factor 1x: bits 0, 64, 200, 255 -> lanes 0, 1, 3 then lane 3 again
        m = '0; m[0] = 1'b1; m[64] = 1'b1; m[200] = 1'b1; m[255] = 1'b1;
        accept(m, 2'd0, 4'd3);
        check("f0_c1_vld", 64'(disp_valid_o), 64'd1);
        check("f0_c1_lanes", 64'(disp_lane_valid_o), 64'b1011);
        check("f0_c1_tid", 64'(disp_tid_o), {16'd0, 12'h3C8, 12'h000, 12'h340, 12'h300});
        check("f0_c1_busy", {62'd0, busy_o, mask_ready_o}, 64'b10);
        step();
        check("f0_c2_lanes", 64'(disp_lane_valid_o), 64'b1000);
        check("f0_c2_tid3", 64'(tid(3)), 64'h3FF);
        check("f0_c2_tid0", 64'(tid(0)), 64'h000);
        step();
        expect_tail("f0", 1'b0);

        // factor 2x: bits 16, 48 both land in lane 1
        m = '0; m[16] = 1'b1; m[48] = 1'b1;
        accept(m, 2'd1, 4'd5);
        check("f1_c1_lanes", 64'(disp_lane_valid_o), 64'b0010);
        check("f1_c1_tid", 64'(disp_tid_o), {16'd0, 12'h000, 12'h000, 12'h510, 12'h000});
        step();
        check("f1_c2_lanes", 64'(disp_lane_valid_o), 64'b0010);
        check("f1_c2_tid1", 64'(tid(1)), 64'h530);
        step();
        expect_tail("f1", 1'b0);

        // factor 4x: bits 9, 137 both land in lane 1
        m = '0; m[9] = 1'b1; m[137] = 1'b1;
        accept(m, 2'd2, 4'd6);
        check("f2_c1_lanes", 64'(disp_lane_valid_o), 64'b0010);
        check("f2_c1_tid1", 64'(tid(1)), 64'h609);
        step();
        check("f2_c2_tid1", 64'(tid(1)), 64'h689);
        step();
        expect_tail("f2", 1'b0);

        // Backpressure: lane 0 holds tid 0 for 4 cycles, then 1, 2, 3
        m = '0; m[3:0] = 4'hF;
        disp_ready_i = 1'b0;
        accept(m, 2'd0, 4'd1);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) disp_ready_i = 1'b1;
            check("bp_hold_vld", 64'(disp_valid_o), 64'd1);
            check("bp_hold_tid", 64'(disp_tid_o), {36'd0, 12'h100});
            step();
        end
        for (int t = 1; t < 4; t++) begin
            check("bp_seq_lanes", 64'(disp_lane_valid_o), 64'b0001);
            check("bp_seq_tid", 64'(tid(0)), 64'(12'h100 + 12'(t)));
            step();
        end
        expect_tail("bp", 1'b0);
`ifdef DISPATCH_SCHED_PERF_EN
        check("perf_stall", 64'(perf_o[95:64]), 64'd3);
        check("perf_disp", 64'(perf_o[63:32]), 64'd10);
        check("perf_chunks", 64'(perf_o[31:0]), 64'd4);
`endif

        // Empty mask: no dispatch, done 2 cycles after accept, no error
        accept('0, 2'd0, 4'd7);
        check("zero_busy", 64'(busy_o), 64'd1);
        expect_tail("zero", 1'b0);

        // Illegal factor: no dispatch, done with err
        accept('1, 2'd3, 4'd8);
        expect_tail("ill", 1'b1);

        // Reset mid-RUN abandons the chunk
        m = '0; m[3:0] = 4'hF;
        disp_ready_i = 1'b0;
        accept(m, 2'd0, 4'd9);
        check("rr_vld", 64'(disp_valid_o), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rr_outs", {58'd0, disp_valid_o, disp_lane_valid_o, done_o}, 64'd0);
        check("rr_ready", {62'd0, mask_ready_o, busy_o}, 64'b10);
        check("rr_tid", 64'(disp_tid_o), 64'd0);
        step();
        check("rr_nodone", {62'd0, done_o, err_o}, 64'd0);
        disp_ready_i = 1'b1;
        m = '0; m[5] = 1'b1;
        accept(m, 2'd0, 4'd2);
        check("rr_new_lanes", 64'(disp_lane_valid_o), 64'b0001);
        check("rr_new_tid", 64'(tid(0)), 64'h205);
        step();
        expect_tail("rr", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
